// File: rtl/returns_desk_scheduler_pkg.sv
// Shared types and item-evaluation rules for the two-lane returns desk.
package returns_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      REPORT = 2'd2,
      ALARM  = 2'd3
   } state_t;

   localparam int UPC_U = 2;
   localparam int UPC_P = 1;
   localparam int UPC_C = 0;

   function automatic logic is_discount(input logic [2:0] upc);
      return upc[UPC_P] | (upc[UPC_U] & upc[UPC_C]);
   endfunction

   function automatic logic is_stolen(input logic [2:0] upc, input logic mark);
      return upc[UPC_U] & ~upc[UPC_C] & ~upc[UPC_P] & ~mark;
   endfunction

endpackage

// File: rtl/returns_desk_scheduler_if.sv
// Lane request/result bundle between the front end (master) and the scheduler (slave).
interface returns_desk_scheduler_if #(
   parameter int CW = 8
);
   logic [1:0]    req;
   logic [2:0]    upc0;
   logic [2:0]    upc1;
   logic          mark0;
   logic          mark1;
   logic          alarm_ack;
   logic [1:0]    grant;
   logic          res_valid;
   logic          res_lane;
   logic          res_discount;
   logic          res_stolen;
   logic          alarm;
   logic [CW-1:0] cnt_total;
   logic [CW-1:0] cnt_disc;
   logic [CW-1:0] cnt_stolen;

   modport master (
      output req, upc0, upc1, mark0, mark1, alarm_ack,
      input  grant, res_valid, res_lane, res_discount, res_stolen, alarm,
             cnt_total, cnt_disc, cnt_stolen
   );

   modport slave (
      input  req, upc0, upc1, mark0, mark1, alarm_ack,
      output grant, res_valid, res_lane, res_discount, res_stolen, alarm,
             cnt_total, cnt_disc, cnt_stolen
   );
endinterface

// File: rtl/returns_item_checker.sv
// Combinational discount/stolen evaluation of one captured item.
module returns_item_checker
   import returns_pkg::*;
(
   input  logic [2:0] i_upc,
   input  logic       i_mark,
   output logic       o_discount,
   output logic       o_stolen
);

   assign o_discount = is_discount(i_upc);
   assign o_stolen   = is_stolen(i_upc, i_mark);

endmodule

// File: rtl/returns_desk_scheduler.sv
// Round-robin arbiter and FSM sharing one item checker between two return lanes,
// with saturating statistics and a stolen-item alarm held until acknowledged.
module returns_desk_scheduler
   import returns_pkg::*;
#(
   parameter int CW       = 8,
   parameter bit ALARM_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   returns_desk_scheduler_if.slave  bus
);

   state_t        r_state;
   logic          r_rr_ptr;
   logic [2:0]    r_upc;
   logic          r_mark;
   logic [1:0]    r_grant;
   logic          r_res_valid;
   logic          r_res_lane;
   logic          r_res_discount;
   logic          r_res_stolen;
   logic          r_alarm;
   logic [CW-1:0] r_cnt_total;
   logic [CW-1:0] r_cnt_disc;
   logic [CW-1:0] r_cnt_stolen;

   logic          w_sel_lane;
   logic [2:0]    w_sel_upc;
   logic          w_sel_mark;
   logic          w_discount;
   logic          w_stolen;

   // Lane choice: a lone requester wins outright, a tie goes to the round-robin pointer.
   always_comb begin
      w_sel_lane = r_rr_ptr;
      case (bus.req)
         2'b01:   w_sel_lane = 1'b0;
         2'b10:   w_sel_lane = 1'b1;
         2'b11:   w_sel_lane = r_rr_ptr;
         default: w_sel_lane = r_rr_ptr;
      endcase
   end

   assign w_sel_upc  = w_sel_lane ? bus.upc1  : bus.upc0;
   assign w_sel_mark = w_sel_lane ? bus.mark1 : bus.mark0;

   returns_item_checker u_checker (
      .i_upc      (r_upc),
      .i_mark     (r_mark),
      .o_discount (w_discount),
      .o_stolen   (w_stolen)
   );

   // Scheduler FSM, capture registers, result registers and saturating counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_rr_ptr       <= 1'b0;
         r_upc          <= 3'b000;
         r_mark         <= 1'b0;
         r_grant        <= 2'b00;
         r_res_valid    <= 1'b0;
         r_res_lane     <= 1'b0;
         r_res_discount <= 1'b0;
         r_res_stolen   <= 1'b0;
         r_alarm        <= 1'b0;
         r_cnt_total    <= '0;
         r_cnt_disc     <= '0;
         r_cnt_stolen   <= '0;
      end else begin
         r_grant     <= 2'b00;
         r_res_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  r_upc      <= w_sel_upc;
                  r_mark     <= w_sel_mark;
                  r_res_lane <= w_sel_lane;
                  r_grant    <= w_sel_lane ? 2'b10 : 2'b01;
                  r_state    <= CHECK;
               end
            end
            CHECK: begin
               r_rr_ptr       <= ~r_res_lane;
               r_res_discount <= w_discount;
               r_res_stolen   <= w_stolen;
               r_res_valid    <= 1'b1;
               r_state        <= REPORT;
            end
            REPORT: begin
               if (r_cnt_total != {CW{1'b1}})
                  r_cnt_total <= r_cnt_total + CW'(1);
               if (r_res_discount && (r_cnt_disc != {CW{1'b1}}))
                  r_cnt_disc <= r_cnt_disc + CW'(1);
               if (r_res_stolen && (r_cnt_stolen != {CW{1'b1}}))
                  r_cnt_stolen <= r_cnt_stolen + CW'(1);
               if (r_res_stolen && ALARM_EN) begin
                  r_state <= ALARM;
                  r_alarm <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            ALARM: begin
               if (bus.alarm_ack) begin
                  r_state <= IDLE;
                  r_alarm <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_alarm <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant        = r_grant;
   assign bus.res_valid    = r_res_valid;
   assign bus.res_lane     = r_res_lane;
   assign bus.res_discount = r_res_discount;
   assign bus.res_stolen   = r_res_stolen;
   assign bus.alarm        = r_alarm;
   assign bus.cnt_total    = r_cnt_total;
   assign bus.cnt_disc     = r_cnt_disc;
   assign bus.cnt_stolen   = r_cnt_stolen;

endmodule

// File: tb/tb_returns_desk_scheduler.sv
// Directed bench: full-width scheduler for arbitration/alarm/reset, a CW=2 copy for saturation.
module tb_returns_desk_scheduler;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;
   int   n_grants;

   returns_desk_scheduler_if #(.CW(8)) bus_a ();
   returns_desk_scheduler_if #(.CW(2)) bus_b ();

   returns_desk_scheduler #(.CW(8), .ALARM_EN(1'b1)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   returns_desk_scheduler #(.CW(2), .ALARM_EN(1'b1)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges and settle just after the last one.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".grant"},  32'(bus_a.grant), 32'd0);
      chk({tag, ".valid"},  32'(bus_a.res_valid), 32'd0);
      chk({tag, ".lane"},   32'(bus_a.res_lane), 32'd0);
      chk({tag, ".disc"},   32'(bus_a.res_discount), 32'd0);
      chk({tag, ".stolen"}, 32'(bus_a.res_stolen), 32'd0);
      chk({tag, ".alarm"},  32'(bus_a.alarm), 32'd0);
      chk({tag, ".ctot"},   32'(bus_a.cnt_total), 32'd0);
      chk({tag, ".cdisc"},  32'(bus_a.cnt_disc), 32'd0);
      chk({tag, ".cstol"},  32'(bus_a.cnt_stolen), 32'd0);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      n_grants = 0;
      reset = 1'b1;
      bus_a.req = 2'b00; bus_a.upc0 = 3'b000; bus_a.upc1 = 3'b000;
      bus_a.mark0 = 1'b0; bus_a.mark1 = 1'b0; bus_a.alarm_ack = 1'b0;
      bus_b.req = 2'b00; bus_b.upc0 = 3'b000; bus_b.upc1 = 3'b000;
      bus_b.mark0 = 1'b0; bus_b.mark1 = 1'b0; bus_b.alarm_ack = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(5);
      chk_all_zero("idle");

      // Single lane-0 discount item
      bus_a.req = 2'b01; bus_a.upc0 = 3'b110; bus_a.mark0 = 1'b0;
      tick(1);
      chk("t2.grant", 32'(bus_a.grant), 32'd1);
      bus_a.req = 2'b00;
      tick(1);
      chk("t2.valid", 32'(bus_a.res_valid), 32'd1);
      chk("t2.disc", 32'(bus_a.res_discount), 32'd1);
      chk("t2.stolen", 32'(bus_a.res_stolen), 32'd0);
      chk("t2.lane", 32'(bus_a.res_lane), 32'd0);
      chk("t2.grant_off", 32'(bus_a.grant), 32'd0);
      tick(1);
      chk("t2.valid_off", 32'(bus_a.res_valid), 32'd0);
      chk("t2.ctot", 32'(bus_a.cnt_total), 32'd1);
      chk("t2.cdisc", 32'(bus_a.cnt_disc), 32'd1);
      chk("t2.cstol", 32'(bus_a.cnt_stolen), 32'd0);

      reset = 1'b1;
      tick(1);
      reset = 1'b0;

      // Both lanes stolen items, ack held: strict alternation, one alarm cycle each
      bus_a.req = 2'b11; bus_a.upc0 = 3'b100; bus_a.upc1 = 3'b100;
      bus_a.mark0 = 1'b0; bus_a.mark1 = 1'b0; bus_a.alarm_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("t3.grant", 32'(bus_a.grant), (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("t3.alarm_chk", 32'(bus_a.alarm), 32'd0);
         tick(1);
         chk("t3.valid", 32'(bus_a.res_valid), 32'd1);
         chk("t3.stolen", 32'(bus_a.res_stolen), 32'd1);
         chk("t3.lane", 32'(bus_a.res_lane), 32'(i % 2));
         tick(1);
         chk("t3.alarm_on", 32'(bus_a.alarm), 32'd1);
         chk("t3.alarm_grant", 32'(bus_a.grant), 32'd0);
         chk("t3.cstol", 32'(bus_a.cnt_stolen), 32'(i + 1));
         tick(1);
         chk("t3.alarm_off", 32'(bus_a.alarm), 32'd0);
      end
      chk("t3.ctot", 32'(bus_a.cnt_total), 32'd3);
      chk("t3.cdisc", 32'(bus_a.cnt_disc), 32'd0);

      // Alarm held without ack; lane 1 is next after lane 0 went last
      bus_a.alarm_ack = 1'b0;
      tick(1);
      chk("t4.grant", 32'(bus_a.grant), 32'd2);
      tick(1);
      chk("t4.lane", 32'(bus_a.res_lane), 32'd1);
      tick(1);
      for (int i = 0; i < 10; i++) begin
         chk("t4.alarm_hold", 32'(bus_a.alarm), 32'd1);
         chk("t4.no_grant", 32'(bus_a.grant), 32'd0);
         tick(1);
      end
      chk("t4.alarm_hold_end", 32'(bus_a.alarm), 32'd1);
      bus_a.alarm_ack = 1'b1;
      tick(1);
      chk("t4.alarm_clr", 32'(bus_a.alarm), 32'd0);
      bus_a.alarm_ack = 1'b0;
      tick(1);
      chk("t4.next_grant", 32'(bus_a.grant), 32'd1);
      bus_a.req = 2'b00;
      tick(2);
      chk("t4.alarm_again", 32'(bus_a.alarm), 32'd1);
      chk("t4.cstol", 32'(bus_a.cnt_stolen), 32'd5);

      // Reset while in ALARM
      reset = 1'b1;
      tick(1);
      chk_all_zero("rst_alarm");
      reset = 1'b0;

      // Reset while in CHECK: the captured item must never be reported
      bus_a.req = 2'b01; bus_a.upc0 = 3'b010;
      tick(1);
      chk("t6.grant", 32'(bus_a.grant), 32'd1);
      reset = 1'b1;
      bus_a.req = 2'b00;
      tick(1);
      chk_all_zero("rst_check");
      reset = 1'b0;
      tick(1);
      chk("t6.no_valid", 32'(bus_a.res_valid), 32'd0);
      tick(1);
      chk("t6.ctot", 32'(bus_a.cnt_total), 32'd0);
      chk("t6.cdisc", 32'(bus_a.cnt_disc), 32'd0);
      bus_a.req = 2'b11;
      tick(1);
      chk("t6.rr_reset", 32'(bus_a.grant), 32'd1);
      bus_a.req = 2'b00;
      tick(3);

      // CW=2 copy: five discount items saturate at 3
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      bus_b.req = 2'b01; bus_b.upc0 = 3'b010; bus_b.mark0 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (bus_b.grant == 2'b01) n_grants++;
      end
      bus_b.req = 2'b00;
      tick(2);
      chk("t5.grants", 32'(n_grants), 32'd5);
      chk("t5.ctot", 32'(bus_b.cnt_total), 32'd3);
      chk("t5.cdisc", 32'(bus_b.cnt_disc), 32'd3);
      chk("t5.cstol", 32'(bus_b.cnt_stolen), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
